// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator and its checker.
package lfsr_pkg;

  localparam logic [7:0] LFSR_SEED = 8'hBD;

  typedef enum logic {HUNT, LOCKED} chk_state_t;

  // Taps 7,3,2,1; shift toward MSB, feedback into bit 0.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] d);
    return {d[6:0], d[1] ^ d[2] ^ d[3] ^ d[7]};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising LFSR stream checker: hunts for lock, then flywheels its
// own prediction and counts mismatches, dropping lock after repeated misses.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);
  localparam logic [MATCH_W-1:0] LOCK_M = MATCH_W'(LOCK_THRESH);
  localparam logic [MISS_W-1:0]  LOSS_M = MISS_W'(LOSS_THRESH);

  chk_state_t         state, state_n;
  logic [7:0]         expected, exp_n;
  logic               primed, primed_n;
  logic [MATCH_W-1:0] match_run, match_n, match_inc;
  logic [MISS_W-1:0]  miss_run, miss_n, miss_inc;
  logic               pulse_n;
  logic [CNT_W-1:0]   cnt_n;

  assign match_inc = match_run + MATCH_W'(1);
  assign miss_inc  = miss_run + MISS_W'(1);

  always_comb begin
    state_n  = state;
    exp_n    = expected;
    primed_n = primed;
    match_n  = match_run;
    miss_n   = miss_run;
    pulse_n  = 1'b0;
    cnt_n    = err_count;
    if (in_valid) begin
      case (state)
        HUNT: begin
          exp_n = lfsr8_next(in_data);
          if (!primed) begin
            primed_n = 1'b1;
            match_n  = '0;
          end else if (in_data == expected && in_data != 8'h00) begin
            // An all-zero sample is the LFSR lock-up state, never a valid match.
            if (match_inc == LOCK_M) begin
              state_n = LOCKED;
              match_n = '0;
              miss_n  = '0;
            end else begin
              match_n = match_inc;
            end
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances from itself, never from in_data.
          exp_n = lfsr8_next(expected);
          if (in_data != expected) begin
            pulse_n = 1'b1;
            if (err_count != '1) cnt_n = err_count + CNT_W'(1);
            if (miss_inc == LOSS_M) begin
              state_n  = HUNT;
              primed_n = 1'b0;
              match_n  = '0;
              miss_n   = '0;
            end else begin
              miss_n = miss_inc;
            end
          end else begin
            miss_n = '0;
          end
        end
        default: state_n = HUNT;
      endcase
    end
    if (clear) cnt_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      expected  <= '0;
      primed    <= 1'b0;
      match_run <= '0;
      miss_run  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      expected  <= exp_n;
      primed    <= primed_n;
      match_run <= match_n;
      miss_run  <= miss_n;
      locked    <= (state_n == LOCKED);
      err_pulse <= pulse_n;
      err_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker: directed vectors push expected
// outputs; a monitor pops and compares one cycle later.
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1, in_valid = 1'b0, clear = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        locked, err_pulse;
  logic [15:0] err_count;

  logic        s_rst = 1'b1, s_valid = 1'b0, s_clear = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_locked, s_pulse;
  logic [15:0] s_count;

  always #5 clk = ~clk;

  lfsr_seq_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  // Loss threshold raised so a long all-error run can reach counter saturation.
  lfsr_seq_checker #(.LOCK_THRESH(4), .LOSS_THRESH(70000), .CNT_W(16)) sat_dut (
    .clk(clk), .rst(s_rst), .in_valid(s_valid), .in_data(s_data), .clear(s_clear),
    .locked(s_locked), .err_pulse(s_pulse), .err_count(s_count)
  );

  typedef struct {
    bit          sel;
    bit          l;
    bit          p;
    logic [15:0] c;
    string       name;
  } exp_t;

  exp_t  q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string phase = "reset";

  // Hand-computed stream from the seed: S[k+1] = next(S[k]).
  logic [7:0] S [0:22] = '{8'hBD, 8'h7B, 8'hF6, 8'hED, 8'hDB, 8'hB7, 8'h6F, 8'hDF,
                           8'hBE, 8'h7C, 8'hF8, 8'hF0, 8'hE1, 8'hC3, 8'h86, 8'h0D,
                           8'h1A, 8'h34, 8'h69, 8'hD3, 8'hA6, 8'h4D, 8'h9A};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic al, ap;
      logic [15:0] ac;
      e  = q.pop_front();
      al = e.sel ? s_locked : locked;
      ap = e.sel ? s_pulse  : err_pulse;
      ac = e.sel ? s_count  : err_count;
      n_vec++;
      if (al !== e.l || ap !== e.p || ac !== e.c) begin
        n_err++;
        $display("FAIL %s: got locked=%0b pulse=%0b count=%h, want locked=%0b pulse=%0b count=%h",
                 e.name, al, ap, ac, e.l, e.p, e.c);
      end
    end
  end

  task automatic step(input bit sel, input bit r, input bit v, input logic [7:0] d,
                      input bit clr, input bit push, input bit el, input bit ep,
                      input logic [15:0] ec);
    exp_t e;
    @(negedge clk);
    if (sel) begin
      s_rst = r; s_valid = v; s_data = d; s_clear = clr;
      rst = 1'b0; in_valid = 1'b0; clear = 1'b0;
    end else begin
      rst = r; in_valid = v; in_data = d; clear = clr;
      s_rst = 1'b0; s_valid = 1'b0; s_clear = 1'b0;
    end
    @(posedge clk);
    if (push) begin
      e.sel = sel; e.l = el; e.p = ep; e.c = ec; e.name = phase;
      q.push_back(e);
    end
  endtask

  // Main DUT, one vector, always checked.
  task automatic m(input bit v, input logic [7:0] d, input bit clr,
                   input bit el, input bit ep, input logic [15:0] ec);
    step(1'b0, 1'b0, v, d, clr, 1'b1, el, ep, ec);
  endtask

  initial begin
    phase = "reset";
    step(0, 1, 0, 8'h00, 0, 1, 0, 0, 16'd0);
    step(0, 1, 1, 8'hBD, 1, 1, 0, 0, 16'd0);

    phase = "lock_acq";
    for (int k = 0; k < 4; k++) m(1, S[k], 0, 0, 0, 16'd0);
    m(1, S[4], 0, 1, 0, 16'd0);

    phase = "single_err";
    m(1, 8'hB6, 0, 1, 1, 16'd1);
    m(1, S[6], 0, 1, 0, 16'd1);
    m(1, S[7], 0, 1, 0, 16'd1);

    phase = "gap";
    repeat (3) m(0, 8'h55, 0, 1, 0, 16'd1);
    m(1, S[8], 0, 1, 0, 16'd1);
    m(0, 8'h00, 0, 1, 0, 16'd1);
    m(1, S[9], 0, 1, 0, 16'd1);
    repeat (5) m(0, 8'hAA, 0, 1, 0, 16'd1);
    m(1, S[10], 0, 1, 0, 16'd1);

    phase = "clear_vs_err";
    m(1, 8'h00, 1, 1, 1, 16'd0);
    m(1, S[12], 0, 1, 0, 16'd0);

    phase = "loss";
    m(1, 8'h00, 0, 1, 1, 16'd1);
    m(1, 8'h00, 0, 1, 1, 16'd2);
    m(1, 8'h00, 0, 0, 1, 16'd3);
    phase = "relock";
    for (int k = 16; k < 20; k++) m(1, S[k], 0, 0, 0, 16'd3);
    m(1, S[20], 0, 1, 0, 16'd3);

    phase = "reset_mid_lock";
    m(1, 8'h00, 0, 1, 1, 16'd4);
    m(1, 8'h00, 0, 1, 1, 16'd5);
    step(0, 1, 1, S[0], 0, 1, 0, 0, 16'd0);
    for (int k = 0; k < 4; k++) m(1, S[k], 0, 0, 0, 16'd0);
    m(1, S[4], 0, 1, 0, 16'd0);

    phase = "zero_stream";
    step(0, 1, 0, 8'h00, 0, 1, 0, 0, 16'd0);
    repeat (8) m(1, 8'h00, 0, 0, 0, 16'd0);

    phase = "sat";
    step(1, 1, 0, 8'h00, 0, 1, 0, 0, 16'd0);
    for (int k = 0; k < 4; k++) step(1, 0, 1, S[k], 0, 1, 0, 0, 16'd0);
    step(1, 0, 1, S[4], 0, 1, 1, 0, 16'd0);
    for (int i = 1; i < 65535; i++) step(1, 0, 1, 8'h00, 0, 0, 0, 0, 16'd0);
    step(1, 0, 1, 8'h00, 0, 1, 1, 1, 16'hFFFF);
    step(1, 0, 1, 8'h00, 0, 1, 1, 1, 16'hFFFF);
    step(1, 0, 0, 8'h00, 0, 1, 1, 0, 16'hFFFF);
    step(1, 0, 0, 8'h00, 1, 1, 1, 0, 16'h0000);

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries still queued, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

Downstream consumer of the 8-bit many-to-one LFSR (taps 7, 3, 2, 1; shift toward MSB; feedback into bit 0).
- Self-synchronizes to the incoming pseudo-random byte stream, then flywheels its own prediction.
- Flags and counts mismatches, and drops lock after repeated misses.
- Sits between the LFSR and any link or BIST status logic as the pattern verifier.

## Interface
Parameters:
- LOCK_THRESH, 4: consecutive correct predictions needed in HUNT to enter LOCKED.
- LOSS_THRESH, 3: consecutive mismatches in LOCKED that force a return to HUNT.
- CNT_W, 16: width of the error counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is a new LFSR sample this cycle.
- in_data  in  8  sample under check.
- clear  in  1  synchronous clear of err_count.
- locked  out  1  registered; high while in LOCKED.
- err_pulse  out  1  registered; one-cycle pulse per mismatch seen in LOCKED.
- err_count  out  CNT_W  registered, saturating mismatch count.

## Operation
- Next-state function: nxt(d) = {d[6:0], d[1]^d[2]^d[3]^d[7]}.
- Internal state:
  - FSM state: HUNT or LOCKED.
  - expected[7:0].
  - primed flag.
  - match_run and miss_run counters, each sized to its threshold.
- The module acts only on cycles with in_valid=1. When in_valid=0, all state holds and err_pulse=0.
- HUNT, on a valid sample:
  - If primed=0: set expected=nxt(in_data), set primed=1, set match_run=0.
  - Else, if in_data==expected and in_data!=0: match_run+1. Otherwise match_run=0. An all-zero sample never counts as a match.
  - In both cases, expected=nxt(in_data).
  - When match_run reaches LOCK_THRESH: go to LOCKED, clear miss_run.
  - No errors are counted in HUNT.
- LOCKED, on a valid sample:
  - expected=nxt(expected). This is flywheel mode: in_data is never reloaded.
  - On a mismatch: err_pulse=1, err_count+1 (saturating at all-ones), miss_run+1.
  - On a match: miss_run=0.
  - When miss_run reaches LOSS_THRESH: go to HUNT with primed=0 and match_run=0.
- clear:
  - Sets err_count to 0.
  - If clear coincides with a mismatch, clear wins: err_count=0, but err_pulse still fires.
  - clear does not affect the FSM.

## Timing
- Reset values: locked=0, err_pulse=0, err_count=0, state=HUNT, primed=0, match_run=0, miss_run=0, expected=0.
- Latency: all outputs are registered and reflect sample N in the cycle after the edge on which sample N was taken.
- locked:
  - Rises one cycle after the LOCK_THRESH-th matching sample is accepted.
  - Falls one cycle after the LOSS_THRESH-th consecutive mismatch.
- The mismatch that causes loss of lock still pulses err_pulse and increments err_count.
- Back-to-back valid samples are supported every cycle. Gaps in in_valid are transparent: the prediction does not advance during a gap.
- Reset mid-operation: all state returns to reset values on that edge, regardless of in_valid or clear.
- Saturation: err_count stays at 2^CNT_W−1 and err_pulse continues to pulse.

## Structure
- Shared package lfsr_pkg holds:
  - LFSR_SEED = 8'hBD.
  - Function lfsr8_next(d), the single definition of the tap polynomial, also used by the generator.
  - Enum chk_state_t {HUNT, LOCKED}.
- No sub-module. The checker is a single module that calls lfsr8_next for both the HUNT reload and the LOCKED flywheel.

## Test plan
- Lock acquisition: after reset, feed 0xBD, 0x7B, 0xF6, 0xED, 0xDB with valid=1 every cycle.
  - Required: locked=1 on the cycle after 0xDB is accepted; err_count=0; no err_pulse.
- Single error: locked, feed 0xB7 where 0xB7 is expected, but corrupted to 0xB6.
  - Required: one err_pulse; err_count=1; locked stays 1.
  - The next correct byte (0x6F) matches, because the flywheel ignores the bad sample.
- Loss of lock: locked, feed three consecutive wrong bytes.
  - Required: err_count +3; locked=0 after the third.
  - Re-feeding a clean run of five bytes relocks.
- Gapped valid and zero stream:
  - Insert in_valid=0 gaps of 1–5 cycles mid-sequence: the checker stays locked with no errors.
  - After reset, feed 0x00 repeatedly: locked never rises.
- Counter edges:
  - Force errors until err_count=0xFFFF: one further error keeps 0xFFFF and still pulses err_pulse.
  - clear asserted together with a mismatch gives err_count=0 and err_pulse=1.
- Reset mid-lock: assert rst for one cycle while locked and err_count=5.
  - Required: next cycle locked=0, err_count=0; a fresh 5-byte run is needed to relock.
